// File: rtl/button_pkg.sv
// Shared defaults and helpers for the button debounce filter.
//   N_BTN_DEF        : default number of button channels
//   SYNC_STAGES_DEF  : default synchroniser depth (legal 2..4)
//   DEBOUNCE_CYC_DEF : default debounce window in clocks (legal 2..2^20)
//   cnt_width()      : width of the per-channel debounce counter
package button_pkg;

    localparam int N_BTN_DEF        = 5;
    localparam int SYNC_STAGES_DEF  = 2;
    localparam int DEBOUNCE_CYC_DEF = 100000;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } chan_state_e;

    // Counter only ever holds 0..cyc-1; keep at least one bit for cyc = 2.
    function automatic int cnt_width(input int cyc);
        return (cyc <= 2) ? 1 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/button_filter_chan.sv
// One debounce channel: synchroniser, persistence counter, debounced level
// register and press/release strobe generation.
//   clk           : clock, all state on rising edge
//   rst_n         : asynchronous active-low reset
//   button_raw    : asynchronous pad level, 1 = pressed
//   button_level  : debounced level (registered)
//   press_pulse   : one-clock strobe coincident with level rising
//   release_pulse : one-clock strobe coincident with level falling
//
// state   | meaning
// STABLE  | synchronised input equals level, counter idle at 0
// PENDING | synchronised input differs from level, counter running
module button_filter_chan
    import button_pkg::*;
#(
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_raw,
    output logic button_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_d;
    logic             press_d;
    logic             release_d;
    logic             mismatch;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw};
        end
    end

    assign mismatch = (sync != button_level);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = button_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            STABLE: begin
                // First differing sample counts as one; DEBOUNCE_CYC >= 2
                // guarantees this can never already be the terminal count.
                if (mismatch) begin
                    state_d = PENDING;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            PENDING: begin
                if (!mismatch) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = STABLE;
                    cnt_d     = '0;
                    level_d   = sync;
                    press_d   = sync;
                    release_d = ~sync;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes are loaded on the same edge as the level so they line up with
    // the first clock of the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= STABLE;
            cnt_q         <= '0;
            button_level  <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            button_level  <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

endmodule

// File: rtl/button_filter.sv
// Multi-channel button debounce filter; one independent filter per button.
//   clk           : clock, all state on rising edge
//   rst_n         : asynchronous active-low reset (deassertion synchronised upstream)
//   button_raw    : N_BTN asynchronous bouncing pad levels, 1 = pressed
//   button_level  : N_BTN debounced registered levels
//   press_pulse   : N_BTN one-clock strobes on level 0->1
//   release_pulse : N_BTN one-clock strobes on level 1->0
module button_filter
    import button_pkg::*;
#(
    parameter int N_BTN        = N_BTN_DEF,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] button_raw,
    output logic [N_BTN-1:0] button_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_filter_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .button_raw    (button_raw[i]),
            .button_level  (button_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_filter.sv
module tb_button_filter;

    localparam int N = 5;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] raw;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;

    int tests;
    int fails;

    button_filter #(
        .N_BTN        (N),
        .SYNC_STAGES  (2),
        .DEBOUNCE_CYC (4)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .button_raw    (raw),
        .button_level  (level),
        .press_pulse   (press),
        .release_pulse (rel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] lvl,
                              input logic [N-1:0] prs, input logic [N-1:0] rls);
        chk({tag, ".level"},   level, lvl);
        chk({tag, ".press"},   press, prs);
        chk({tag, ".release"}, rel,   rls);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        raw   = 5'b11111;
        rst_n = 1'b1;

        // Asynchronous reset with all buttons pressed
        #2 rst_n = 1'b0;
        #1;
        expect_out("rst_async", 5'b00000, 5'b00000, 5'b00000);
        tick(2);
        expect_out("rst_hold", 5'b00000, 5'b00000, 5'b00000);

        // Buttons held through reset release: accepted after 2 + 4 edges
        rst_n = 1'b1;
        tick(5);
        expect_out("por_e5", 5'b00000, 5'b00000, 5'b00000);
        tick(1);
        expect_out("por_e6", 5'b11111, 5'b11111, 5'b00000);
        tick(1);
        expect_out("por_e7", 5'b11111, 5'b00000, 5'b00000);

        // Channels 0 and 2 released together
        raw = 5'b11010;
        tick(5);
        expect_out("rel02_e5", 5'b11111, 5'b00000, 5'b00000);
        tick(1);
        expect_out("rel02_e6", 5'b11010, 5'b00000, 5'b00101);
        tick(1);
        expect_out("rel02_e7", 5'b11010, 5'b00000, 5'b00000);

        // Channel 0 clean press
        raw = 5'b11011;
        tick(5);
        expect_out("press0_e5", 5'b11010, 5'b00000, 5'b00000);
        tick(1);
        expect_out("press0_e6", 5'b11011, 5'b00001, 5'b00000);
        tick(1);
        expect_out("press0_e7", 5'b11011, 5'b00000, 5'b00000);

        // Channel 2 chatters every clock: never accepted
        for (int k = 0; k < 20; k++) begin
            raw[2] = (k % 2 == 0);
            tick(1);
            expect_out($sformatf("bounce2_%0d", k), 5'b11011, 5'b00000, 5'b00000);
        end
        raw[2] = 1'b0;
        tick(6);
        expect_out("bounce2_end", 5'b11011, 5'b00000, 5'b00000);

        // Channel 3 released to set up the glitch case
        raw = 5'b10011;
        tick(6);
        expect_out("rel3_e6", 5'b10011, 5'b00000, 5'b01000);
        tick(1);
        expect_out("rel3_e7", 5'b10011, 5'b00000, 5'b00000);

        // Channel 3: high 3, low 1, high held; count restarts after glitch
        raw[3] = 1'b1;
        tick(3);
        raw[3] = 1'b0;
        tick(1);
        raw[3] = 1'b1;
        tick(2);
        expect_out("glitch3_e6", 5'b10011, 5'b00000, 5'b00000);
        tick(3);
        expect_out("glitch3_e9", 5'b10011, 5'b00000, 5'b00000);
        tick(1);
        expect_out("glitch3_e10", 5'b11011, 5'b01000, 5'b00000);
        tick(1);
        expect_out("glitch3_e11", 5'b11011, 5'b00000, 5'b00000);

        // Channels 1 and 4 released on the same edge
        raw = 5'b01001;
        tick(5);
        expect_out("rel14_e5", 5'b11011, 5'b00000, 5'b00000);
        tick(1);
        expect_out("rel14_e6", 5'b01001, 5'b00000, 5'b10010);
        tick(1);
        expect_out("rel14_e7", 5'b01001, 5'b00000, 5'b00000);

        // Channel 0 released
        raw = 5'b01000;
        tick(6);
        expect_out("rel0_e6", 5'b01000, 5'b00000, 5'b00001);
        tick(1);
        expect_out("rel0_e7", 5'b01000, 5'b00000, 5'b00000);

        // Channel 0 pressed, reset hits with the count at 2
        raw = 5'b01001;
        tick(4);
        expect_out("pend0_e4", 5'b01000, 5'b00000, 5'b00000);
        rst_n = 1'b0;
        #1;
        expect_out("midrst_async", 5'b00000, 5'b00000, 5'b00000);
        raw = 5'b00000;
        tick(2);
        expect_out("midrst_hold", 5'b00000, 5'b00000, 5'b00000);
        rst_n = 1'b1;
        tick(4);
        expect_out("midrst_post4", 5'b00000, 5'b00000, 5'b00000);
        tick(4);
        expect_out("midrst_post8", 5'b00000, 5'b00000, 5'b00000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_filter.md
BUTTON_FILTER -- requirements
Module: button_filter

Interface
REQ-001 Parameter N_BTN, default 5: number of independent button channels.
REQ-002 Parameter SYNC_STAGES, default 2, legal range 2..4: flip-flop stages in the input synchroniser.
REQ-003 Parameter DEBOUNCE_CYC, default 100000, legal range 2..2^20: consecutive clocks a new level must persist before it is accepted.
REQ-004 Port clk, input, 1 bit: single clock; all state on rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port button_raw, input, N_BTN bits: asynchronous, bouncing pad levels, 1 = pressed.
REQ-007 Port button_level, output, N_BTN bits: debounced registered level per channel; feeds the downstream edge-detect stage.
REQ-008 Port press_pulse, output, N_BTN bits: one-clock strobe when button_level of that channel goes 0->1.
REQ-009 Port release_pulse, output, N_BTN bits: one-clock strobe when button_level of that channel goes 1->0.

Function
REQ-010 Each channel shall pass button_raw[i] through a SYNC_STAGES-deep flip-flop chain; its last stage is sync[i]; no logic between stages.
REQ-011 Each channel shall hold a counter cnt[i] of width CNT_W = clog2(DEBOUNCE_CYC), unsigned, never exceeding DEBOUNCE_CYC-1.
REQ-012 Per clock, if sync[i] == button_level[i], cnt[i] shall load 0.
REQ-013 Per clock, if sync[i] != button_level[i] and cnt[i] < DEBOUNCE_CYC-1, cnt[i] shall increment by 1.
REQ-014 Per clock, if sync[i] != button_level[i] and cnt[i] == DEBOUNCE_CYC-1, button_level[i] shall load sync[i] and cnt[i] shall load 0 on that same edge.
REQ-015 A single mismatching sample followed by a matching one (bounce) shall clear cnt[i]; button_level[i] shall not change.
REQ-016 Latency: a clean step on button_raw[i], held steady, shall appear on button_level[i] exactly SYNC_STAGES + DEBOUNCE_CYC clocks after the first capturing edge.
REQ-017 press_pulse[i] shall be registered and asserted for exactly the one clock following the edge on which button_level[i] rose; release_pulse[i] likewise for a fall.
REQ-018 press_pulse[i] and release_pulse[i] shall never be high together; pulses on different channels may coincide.
REQ-019 Channels shall be fully independent; simultaneous changes on several channels shall each be filtered with identical timing.
REQ-020 Per-channel behaviour is a two-state machine: STABLE (cnt = 0, sync == level) and PENDING (sync != level, counting); PENDING->STABLE on match (discard) or on terminal count (accept).

Reset
REQ-021 While rst_n = 0: all synchroniser flops, cnt, button_level, press_pulse and release_pulse shall be 0, immediately and independently of clk.
REQ-022 rst_n deassertion shall be synchronised externally; after release the block shall start from STABLE with level 0 on every channel.
REQ-023 Reset asserted mid-PENDING shall discard the count; no pulse shall be emitted for the interrupted transition.
REQ-024 A button held pressed through reset release shall produce press_pulse after SYNC_STAGES + DEBOUNCE_CYC clocks.

Structure
REQ-025 Package button_pkg shall hold N_BTN default, SYNC_STAGES default, DEBOUNCE_CYC default and a CNT_W derivation function.
REQ-026 One sub-module, button_filter_chan (synchroniser, counter, level register, pulse generation for one channel), shall be instantiated N_BTN times by a generate loop.
REQ-027 No combinational path from button_raw to any output; all outputs driven directly by flops.

Verification (DEBOUNCE_CYC = 4, SYNC_STAGES = 2)
REQ-028 rst_n low, button_raw = 5'b11111 -> all outputs 0; release reset with input held -> button_level = 5'b11111 and press_pulse = 5'b11111 for one clock, 6 clocks after the first capturing edge.
REQ-029 button_raw[0] 0->1 held -> button_level[0] rises 6 clocks later; press_pulse[0] high exactly 1 clock; other channels unchanged.
REQ-030 button_raw[2] toggles 1,0,1,0 every clock for 20 clocks, then stays 0 -> button_level[2] stays 0, no pulses.
REQ-031 button_raw[3] high 3 clocks, low 1, high held -> level rises only after 4 consecutive synced high samples (count restarts after the glitch).
REQ-032 Channels 1 and 4 released on the same edge -> release_pulse = 5'b10010 in one clock.
REQ-033 rst_n pulsed low while channel 0 is PENDING (cnt = 2) -> cnt cleared, no pulse, button_level[0] = 0.
